path_player: RTL and testbench

PATH_PLAYER -- requirements
Module: path_player

---
 rtl/path_player.sv | 148 ++++++++++++++
 tb/tb_path_player.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_player.sv
// path_player: replays a stored path of X/Y nibble locations as EAST/WEST/SOUTH/NORTH move codes.
// Define PATH_PLAYER_WRAP_CHECK_EN to treat nibble wrap-around (15<->0) as non-adjacent.
module path_player #(
    parameter logic [7:0] MAX_STEPS = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       empStck,
    input  logic [7:0] locIn,
    output logic       pop,
    output logic       run,
    output logic [1:0] dir,
    output logic       dirValid,
    input  logic       dirReady,
    output logic [7:0] stepCount,
    output logic       busy,
    output logic       finished,
    output logic       badStep
);

    typedef enum logic [2:0] {S_IDLE, S_POP, S_LOAD, S_EMIT, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] step_q, step_d;
    logic [7:0] prev_q, prev_d;
    logic [7:0] cur_q, cur_d;
    logic [1:0] dir_q, dir_d;
    logic       bad_q, bad_d;
    logic       first_q, first_d;

    logic [3:0] dx, dy;
    logic       adj;
    logic [1:0] adj_dir;

    // Modulo-16 nibble deltas; +1 and 15 (i.e. -1) are the adjacent cases.
    assign dx = locIn[7:4] - prev_q[7:4];
    assign dy = locIn[3:0] - prev_q[3:0];

    always_comb begin
        adj     = 1'b0;
        adj_dir = 2'b00;
        if (dy == 4'd0) begin
            if (dx == 4'd1) begin
                adj     = 1'b1;
                adj_dir = 2'b00;
            end else if (dx == 4'hF) begin
                adj     = 1'b1;
                adj_dir = 2'b01;
            end
        end else if (dx == 4'd0) begin
            if (dy == 4'd1) begin
                adj     = 1'b1;
                adj_dir = 2'b10;
            end else if (dy == 4'hF) begin
                adj     = 1'b1;
                adj_dir = 2'b11;
            end
        end
`ifdef PATH_PLAYER_WRAP_CHECK_EN
        if ((adj_dir == 2'b00 && prev_q[7:4] == 4'hF) ||
            (adj_dir == 2'b01 && prev_q[7:4] == 4'h0) ||
            (adj_dir == 2'b10 && prev_q[3:0] == 4'hF) ||
            (adj_dir == 2'b11 && prev_q[3:0] == 4'h0)) begin
            adj = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            prev_q  <= '0;
            cur_q   <= '0;
            dir_q   <= '0;
            bad_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            dir_q   <= dir_d;
            bad_q   <= bad_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        prev_d  = prev_q;
        cur_d   = cur_q;
        dir_d   = dir_q;
        bad_d   = bad_q;
        first_d = first_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    step_d  = '0;
                    bad_d   = 1'b0;
                    first_d = 1'b1;
                    state_d = empStck ? S_DONE : S_POP;
                end
            end
            // An empty store here has no location to read, so the run ends instead of loading.
            S_POP:  state_d = empStck ? S_DONE : S_LOAD;
            S_LOAD: begin
                cur_d = locIn;
                if (first_q) begin
                    prev_d  = locIn;
                    first_d = 1'b0;
                    state_d = empStck ? S_DONE : S_POP;
                end else if (adj) begin
                    dir_d   = adj_dir;
                    state_d = S_EMIT;
                end else begin
                    bad_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_EMIT: begin
                if (dirReady) begin
                    step_d  = step_q + 8'd1;
                    prev_d  = cur_q;
                    state_d = (step_d == MAX_STEPS || empStck) ? S_DONE : S_POP;
                end
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop       = (state_q == S_POP) && !empStck;
        busy      = (state_q == S_POP) || (state_q == S_LOAD) || (state_q == S_EMIT);
        run       = busy;
        dirValid  = (state_q == S_EMIT);
        finished  = (state_q == S_DONE);
        dir       = dir_q;
        stepCount = step_q;
        badStep   = bad_q;
    end

endmodule

// File: tb/tb_path_player.sv
// Self-checking bench for path_player: a behavioural path store feeds the DUT and a
// pair-by-pair move model predicts the emitted directions, final count and badStep.
module tb_path_player;

    localparam int TB_MAX = 4;
`ifdef PATH_PLAYER_WRAP_CHECK_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       empStck;
    logic [7:0] locIn = 8'h00;
    logic       pop;
    logic       run;
    logic [1:0] dir;
    logic       dirValid;
    logic       dirReady;
    logic [7:0] stepCount;
    logic       busy;
    logic       finished;
    logic       badStep;

    int checks = 0;
    int errors = 0;

    path_player #(.MAX_STEPS(8'(TB_MAX))) dut (
        .clk(clk), .rst(rst), .start(start), .empStck(empStck), .locIn(locIn),
        .pop(pop), .run(run), .dir(dir), .dirValid(dirValid), .dirReady(dirReady),
        .stepCount(stepCount), .busy(busy), .finished(finished), .badStep(badStep)
    );

    always #5 clk = ~clk;

    // Path store: queue of locations, one-cycle read latency after pop.
    logic [7:0] path [16];
    int plen = 0;
    int base = 0;
    int pop_total = 0;
    assign empStck = ((pop_total - base) >= plen);

    always @(posedge clk) begin
        if (pop) begin
            locIn     <= path[(pop_total - base) & 15];
            pop_total <= pop_total + 1;
        end
    end

    // Downstream ready: 0 always ready, 1 random, 2 stall for stall_len cycles of dirValid.
    int rmode = 0;
    int stall_len = 0;
    int vcnt = 0;
    always @(posedge clk) begin
        #1;
        if (rmode == 0) dirReady = 1'b1;
        else if (rmode == 1) dirReady = 1'($urandom_range(0, 1));
        else dirReady = (vcnt >= stall_len);
        if (dirValid) vcnt = vcnt + 1;
        else vcnt = 0;
    end

    // Monitor: record accepted moves and protocol violations.
    logic [1:0] got[$];
    int viol = 0;
    always @(negedge clk) begin
        if (dirValid && dirReady) got.push_back(dir);
        if (pop && empStck) viol = viol + 1;
        if (dirValid && !busy) viol = viol + 1;
    end

    int got_base, viol_base;
    int exp_q[$];
    int exp_bad, exp_pops;

    task automatic model_path(input int n);
        int x0, y0, x1, y1, ddx, ddy;
        exp_q.delete();
        exp_bad  = 0;
        exp_pops = 0;
        if (n == 0) return;
        exp_pops = 1;
        for (int i = 1; i < n; i++) begin
            if (exp_q.size() == TB_MAX) break;
            exp_pops++;
            x0 = int'(path[i-1][7:4]);
            y0 = int'(path[i-1][3:0]);
            x1 = int'(path[i][7:4]);
            y1 = int'(path[i][3:0]);
            ddx = x1 - x0;
            ddy = y1 - y0;
            if (!WRAP) begin
                if (ddx == 15) ddx = -1;
                if (ddx == -15) ddx = 1;
                if (ddy == 15) ddy = -1;
                if (ddy == -15) ddy = 1;
            end
            if (ddx == 1 && ddy == 0) exp_q.push_back(0);
            else if (ddx == -1 && ddy == 0) exp_q.push_back(1);
            else if (ddx == 0 && ddy == 1) exp_q.push_back(2);
            else if (ddx == 0 && ddy == -1) exp_q.push_back(3);
            else begin
                exp_bad = 1;
                break;
            end
        end
    endtask

    task automatic begin_run(input int n, input int mode);
        @(negedge clk);
        base      = pop_total;
        plen      = n;
        rmode     = mode;
        got_base  = got.size();
        viol_base = viol;
        model_path(n);
        start = 1'b1;
    endtask

    task automatic finish_run(input string name);
        int cyc = 0;
        while (!finished && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout: finished=%0b required 1", name, finished);
        end
        @(negedge clk);
        checks++;
        if (!finished || busy) begin
            errors++;
            $display("FAIL %s retrigger: finished=%0b busy=%0b required 1/0", name, finished, busy);
        end
        checks++;
        if (got.size() - got_base != exp_q.size()) begin
            errors++;
            $display("FAIL %s move_count: got %0d required %0d", name, got.size() - got_base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (int'(got[got_base + i]) != exp_q[i]) begin
                    errors++;
                    $display("FAIL %s dir[%0d]: got %0d required %0d", name, i, got[got_base + i], exp_q[i]);
                end
            end
        end
        checks++;
        if (int'(stepCount) != exp_q.size()) begin
            errors++;
            $display("FAIL %s stepCount: got %0d required %0d", name, stepCount, exp_q.size());
        end
        checks++;
        if (int'(badStep) != exp_bad) begin
            errors++;
            $display("FAIL %s badStep: got %0b required %0d", name, badStep, exp_bad);
        end
        checks++;
        if (pop_total - base != exp_pops) begin
            errors++;
            $display("FAIL %s pops: got %0d required %0d", name, pop_total - base, exp_pops);
        end
        checks++;
        if (viol != viol_base) begin
            errors++;
            $display("FAIL %s protocol: violations %0d required 0", name, viol - viol_base);
        end
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (finished || busy) begin
            errors++;
            $display("FAIL %s release: finished=%0b busy=%0b required 0/0", name, finished, busy);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({pop, run, dirValid, busy, finished, badStep, dir, stepCount} !== 15'd0) begin
            errors++;
            $display("FAIL %s: pop=%b run=%b dv=%b busy=%b fin=%b bad=%b dir=%b cnt=%0d required all 0",
                     name, pop, run, dirValid, busy, finished, badStep, dir, stepCount);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_basic();
        path[0] = 8'h11; path[1] = 8'h21; path[2] = 8'h22; path[3] = 8'h12;
        begin_run(4, 0);
        @(negedge clk);
        checks++;
        if (pop !== 1'b1 || run !== 1'b1) begin
            errors++;
            $display("FAIL latency: pop=%b run=%b required 1/1", pop, run);
        end
        finish_run("basic");
    endtask

    task automatic test_bad_jump();
        path[0] = 8'h11; path[1] = 8'h33;
        begin_run(2, 0);
        finish_run("bad_jump");
        path[0] = 8'h45; path[1] = 8'h45;
        begin_run(2, 0);
        finish_run("same_loc");
    endtask

    task automatic test_stall();
        int cyc = 0;
        path[0] = 8'h11; path[1] = 8'h10;
        stall_len = 5;
        begin_run(2, 2);
        while (!dirValid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (dirValid !== 1'b1 || dir !== 2'b11 || stepCount !== 8'd0) begin
                errors++;
                $display("FAIL stall[%0d]: dv=%b dir=%b cnt=%0d required 1/11/0", k, dirValid, dir, stepCount);
            end
            @(negedge clk);
        end
        checks++;
        if (dirValid !== 1'b1 || dirReady !== 1'b1 || stepCount !== 8'd0) begin
            errors++;
            $display("FAIL stall_hs: dv=%b rdy=%b cnt=%0d required 1/1/0", dirValid, dirReady, stepCount);
        end
        @(negedge clk);
        checks++;
        if (stepCount !== 8'd1 || dirValid !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: cnt=%0d dv=%b required 1/0", stepCount, dirValid);
        end
        finish_run("stall");
    endtask

    task automatic test_empty();
        begin_run(0, 0);
        @(negedge clk);
        checks++;
        if (finished !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: finished=%b busy=%b required 1/0", finished, busy);
        end
        finish_run("empty");
    endtask

    task automatic test_max_steps();
        path[0] = 8'h55; path[1] = 8'h65; path[2] = 8'h66;
        path[3] = 8'h67; path[4] = 8'h57; path[5] = 8'h47;
        begin_run(6, 0);
        finish_run("max_steps");
    endtask

    task automatic test_wrap();
        path[0] = 8'hF0; path[1] = 8'h00;
        begin_run(2, 0);
        finish_run("wrap_x");
        path[0] = 8'h30; path[1] = 8'h3F;
        begin_run(2, 0);
        finish_run("wrap_y");
    endtask

    task automatic test_reset_in_emit();
        int cyc = 0;
        path[0] = 8'h11; path[1] = 8'h10;
        stall_len = 1000;
        begin_run(2, 2);
        while (!dirValid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (dirValid !== 1'b1) begin
            errors++;
            $display("FAIL rst_emit_reach: dirValid=%b required 1", dirValid);
        end
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_in_emit");
        checks++;
        if (got.size() != got_base) begin
            errors++;
            $display("FAIL rst_emit_no_hs: moves %0d required 0", got.size() - got_base);
        end
        rst       = 1'b0;
        start     = 1'b0;
        stall_len = 0;
        rmode     = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int x, y, n, r;
        for (int it = 0; it < 25; it++) begin
            n = $urandom_range(0, 9);
            x = $urandom_range(0, 15);
            y = $urandom_range(0, 15);
            for (int i = 0; i < n; i++) begin
                path[i] = 8'((x << 4) | y);
                r = $urandom_range(0, 11);
                if (r == 0) begin
                    x = $urandom_range(0, 15);
                    y = $urandom_range(0, 15);
                end else if (r == 1) begin
                    x = x;
                end else if (r < 4) x = (x + 1) & 15;
                else if (r < 6) x = (x + 15) & 15;
                else if (r < 9) y = (y + 1) & 15;
                else y = (y + 15) & 15;
            end
            begin_run(n, it % 2);
            finish_run("random");
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dirReady = 1'b0;
        test_reset();
        test_basic();
        test_bad_jump();
        test_stall();
        test_empty();
        test_max_steps();
        test_wrap();
        test_reset_in_emit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
